// File: rtl/sixteenbit_serial_addsub_pkg.sv
// Shared widths and FSM encoding for the nibble-serial 16-bit adder/subtractor.
package sixteenbit_serial_addsub_pkg;

    localparam int WIDTH   = 16;
    localparam int SLICE   = 4;
    localparam int NSLICES = WIDTH / SLICE;
    localparam int IDX_W   = $clog2(NSLICES);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fourbit_carrysel.sv
// 4-bit carry-select slice: both carry-in cases are precomputed, the real carry picks one.
module fourbit_carrysel
    import sixteenbit_serial_addsub_pkg::*;
(
    input  logic [SLICE-1:0] i_x,
    input  logic [SLICE-1:0] i_y,
    input  logic             i_cin,
    output logic [SLICE-1:0] o_sum,
    output logic             o_cout
);

    logic [SLICE:0] w_sum0;
    logic [SLICE:0] w_sum1;

    assign w_sum0 = {1'b0, i_x} + {1'b0, i_y};
    assign w_sum1 = w_sum0 + (SLICE+1)'(1);

    assign {o_cout, o_sum} = i_cin ? w_sum1 : w_sum0;

endmodule

// File: rtl/sixteenbit_serial_addsub.sv
// Multi-cycle 16-bit add/subtract: one nibble per clock through a shared carry-select slice,
// carry rippled through a register, Start/Busy/Done handshake around it.
module sixteenbit_serial_addsub
    import sixteenbit_serial_addsub_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Sub,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf
);

    state_t                  r_state;
    logic [IDX_W-1:0]        r_idx;
    logic                    r_carry;
    logic                    r_sub;
    logic [WIDTH-1:0]        r_x;
    logic [WIDTH-1:0]        r_yeff;
    logic [WIDTH-SLICE-1:0]  r_acc;
    logic                    r_busy;
    logic                    r_done;
    logic [WIDTH-1:0]        r_sum;
    logic                    r_cout;
    logic                    r_ovf;

    logic [SLICE-1:0]        w_x_slice;
    logic [SLICE-1:0]        w_y_slice;
    logic [SLICE-1:0]        w_slice_sum;
    logic                    w_slice_cout;
    logic                    w_c15;

    assign w_x_slice = r_x[r_idx*SLICE +: SLICE];
    assign w_y_slice = r_yeff[r_idx*SLICE +: SLICE];

    fourbit_carrysel u_slice (
        .i_x    (w_x_slice),
        .i_y    (w_y_slice),
        .i_cin  (r_carry),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout)
    );

    // Carry into the MSB, recovered from the MSB sum bit, for signed overflow.
    assign w_c15 = r_x[WIDTH-1] ^ r_yeff[WIDTH-1] ^ w_slice_sum[SLICE-1];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sub   <= 1'b0;
            r_x     <= '0;
            r_yeff  <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (Start) begin
                        r_x     <= X;
                        r_yeff  <= Sub ? ~Y : Y;
                        r_sub   <= Sub;
                        r_carry <= Sub ^ Cin;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_carry <= w_slice_cout;
                    if (r_idx == LAST_IDX) begin
                        // Final nibble goes straight to Sum so partial results never show.
                        r_sum   <= {w_slice_sum, r_acc};
                        r_cout  <= r_sub ? ~w_slice_cout : w_slice_cout;
                        r_ovf   <= w_slice_cout ^ w_c15;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= ST_DONE;
                    end else begin
                        r_acc[r_idx*SLICE +: SLICE] <= w_slice_sum;
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Busy = r_busy;
    assign Done = r_done;
    assign Sum  = r_sum;
    assign Cout = r_cout;
    assign Ovf  = r_ovf;

endmodule

// File: tb/tb_sixteenbit_serial_addsub.sv
// Bench for sixteenbit_serial_addsub: directed corner cases plus a random sweep
// scored against an integer-arithmetic reference model.
module tb_sixteenbit_serial_addsub;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    // Expected {ovf, cout, sum} per accepted op, and the op's {sub, cin, x, y} for reporting.
    logic [W+1:0] exp_q[$];
    logic [W*2+1:0] op_q[$];
    logic [W+1:0]   sb_exp;
    logic [W*2+1:0] sb_op;

    sixteenbit_serial_addsub dut (
        .Clk   (clk),
        .Reset (rst),
        .Start (start),
        .Sub   (sub),
        .X     (x),
        .Y     (y),
        .Cin   (cin),
        .Busy  (busy),
        .Done  (done),
        .Sum   (sum),
        .Cout  (cout),
        .Ovf   (ovf)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W+1:0] model(input logic s, input logic c,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
        int ua, ub, sa, sb, ci, r, sr;
        logic [W-1:0] rs;
        logic         rc;
        logic         ro;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        ci = c ? 1 : 0;
        if (!s) begin
            r  = ua + ub + ci;
            rc = (r > 65535);
            sr = sa + sb + ci;
        end else begin
            r  = ua - ub - ci;
            rc = (ua < ub + ci);
            sr = sa - sb - ci;
        end
        rs = r[W-1:0];
        ro = (sr > 32767) || (sr < -32768);
        return {ro, rc, rs};
    endfunction

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                sb_exp = exp_q.pop_front();
                sb_op  = op_q.pop_front();
                check($sformatf("sb x=%h y=%h cin=%0d sub=%0d {ovf,cout,sum}",
                                sb_op[2*W-1:W], sb_op[W-1:0], sb_op[2*W], sb_op[2*W+1]),
                      {14'd0, ovf, cout, sum}, {14'd0, sb_exp});
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic start_op(input logic s, input logic c, input logic [W-1:0] a, input logic [W-1:0] b);
        sub   = s;
        cin   = c;
        x     = a;
        y     = b;
        start = 1'b1;
        exp_q.push_back(model(s, c, a, b));
        op_q.push_back({s, c, a, b});
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic pulse_ignored(input logic [W-1:0] a, input logic [W-1:0] b);
        sub   = ~sub;
        cin   = ~cin;
        x     = a;
        y     = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts clock edges until Done is seen; a missing Done shows up as a latency mismatch.
    task automatic wait_done(input string tag, input int exp_cyc);
        int cyc;
        cyc = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done === 1'b1) break;
        end
        check(tag, cyc, exp_cyc);
    endtask

    task automatic directed(input string tag, input logic s, input logic c,
                            input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf);
        start_op(s, c, a, b);
        check({tag, "_busy"}, busy, 1);
        wait_done({tag, "_latency"}, 4);
        check({tag, "_sum"}, sum, e_sum);
        check({tag, "_cout"}, cout, e_cout);
        check({tag, "_ovf"}, ovf, e_ovf);
        check({tag, "_busy_done"}, busy, 0);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, done, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int d0;
        logic         rs, rc;
        logic [W-1:0] ra, rb;

        rst   = 1'b1;
        start = 1'b0;
        sub   = 1'b0;
        cin   = 1'b0;
        x     = '0;
        y     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum",  sum,  0);
        check("rst_cout", cout, 0);
        check("rst_ovf",  ovf,  0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        directed("add_basic",  1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0);
        directed("add_wrap",   1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        directed("add_ovf",    1'b0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
        directed("add_cin",    1'b0, 1'b1, 16'h00FF, 16'h0000, 16'h0100, 1'b0, 1'b0);
        directed("sub_borrow", 1'b1, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b1, 1'b0);
        directed("sub_ovf",    1'b1, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1);
        directed("sub_bin",    1'b1, 1'b1, 16'h0005, 16'h0005, 16'hFFFF, 1'b1, 1'b0);

        // Start while busy is ignored: one Done, original operands.
        d0 = done_cnt;
        start_op(1'b0, 1'b0, 16'h1111, 16'h2222);
        @(posedge clk);
        #1;
        pulse_ignored(16'hFFFF, 16'hFFFF);
        wait_done("busy_start_latency", 2);
        check("busy_start_sum", sum, 16'h3333);
        repeat (8) @(posedge clk);
        #1;
        check("busy_start_one_done", done_cnt - d0, 1);

        // Back-to-back: Start held during the DONE cycle.
        start_op(1'b0, 1'b1, 16'h0100, 16'h0200);
        wait_done("b2b_first_latency", 4);
        check("b2b_first_sum", sum, 16'h0301);
        start_op(1'b1, 1'b0, 16'h1000, 16'h0001);
        check("b2b_second_busy", busy, 1);
        wait_done("b2b_second_latency", 4);
        check("b2b_second_sum", sum, 16'h0FFF);
        @(posedge clk);
        #1;

        // Reset in the second RUN cycle aborts the op without a Done.
        start_op(1'b0, 1'b0, 16'h00FF, 16'h0001);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum",  sum,  0);
        check("abort_cout", cout, 0);
        check("abort_ovf",  ovf,  0);
        exp_q.delete();
        op_q.delete();
        d0 = done_cnt;
        @(negedge clk) rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        directed("after_abort", 1'b0, 1'b0, 16'hABCD, 16'h1111, 16'hBCDE, 1'b0, 1'b0);

        // Random sweep, occasionally using corner operands and back-to-back issue.
        for (int n = 0; n < 2000; n++) begin
            rs = 1'($urandom_range(0, 1));
            rc = 1'($urandom_range(0, 1));
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 7))
                0: ra = 16'h7FFF;
                1: ra = 16'h8000;
                2: rb = 16'hFFFF;
                3: rb = 16'h0000;
                default: ;
            endcase
            start_op(rs, rc, ra, rb);
            wait_done("rnd_latency", 4);
            if ($urandom_range(0, 1) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (6) @(posedge clk);
        #1;
        check("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
